regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register-file write port: EX/LD round-robin, x0 writes dropped.
// Define ARVI_RF_CLEAR_EN to zero-fill x1..x31 after every reset before requests are accepted.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_ex_valid,
  output logic            o_ex_ready,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_rd,
  input  logic [XLEN-1:0] i_ld_data,
  output logic            o_wen,
  output logic [4:0]      o_wnum,
  output logic [XLEN-1:0] o_wd,
  output logic            o_init_busy
);

  localparam logic PRIO_EX = 1'b0;
  localparam logic PRIO_LD = 1'b1;

  logic       prio;
  logic       run;
  logic       clear_wr;
  logic [4:0] clear_idx;
  logic       ex_xfer;
  logic       ld_xfer;

`ifdef ARVI_RF_CLEAR_EN
  // state | meaning
  // CLEAR | zero-filling x1..x31, requesters stalled
  // RUN   | arbitrating EX/LD write-backs
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] idx;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_CLEAR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && idx == 5'd31) state_nxt = ST_RUN;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                idx <= 5'd1;
    else if (state == ST_CLEAR) idx <= idx + 5'd1;
  end

  assign run         = (state == ST_RUN);
  assign clear_wr    = (state == ST_CLEAR);
  assign clear_idx   = idx;
  assign o_init_busy = (state == ST_CLEAR);
`else
  assign run         = 1'b1;
  assign clear_wr    = 1'b0;
  assign clear_idx   = 5'd0;
  assign o_init_busy = 1'b0;
`endif

  // A requester is only held off when the other is valid and owns the turn.
  always_comb begin
    o_ex_ready = run & (!i_ld_valid | (prio == PRIO_EX));
    o_ld_ready = run & (!i_ex_valid | (prio == PRIO_LD));
    ex_xfer    = i_ex_valid & o_ex_ready;
    ld_xfer    = i_ld_valid & o_ld_ready;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      prio <= PRIO_EX;
    else if (ex_xfer) prio <= PRIO_LD;
    else if (ld_xfer) prio <= PRIO_EX;
  end

  // x0 writes are accepted and still update index/data, but never enable the port.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_wen  <= 1'b0;
      o_wnum <= 5'd0;
      o_wd   <= '0;
    end else if (clear_wr) begin
      o_wen  <= 1'b1;
      o_wnum <= clear_idx;
      o_wd   <= '0;
    end else if (ex_xfer) begin
      o_wen  <= (i_ex_rd != 5'd0);
      o_wnum <= i_ex_rd;
      o_wd   <= i_ex_data;
    end else if (ld_xfer) begin
      o_wen  <= (i_ld_rd != 5'd0);
      o_wnum <= i_ld_rd;
      o_wd   <= i_ld_data;
    end else begin
      o_wen  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: random EX/LD traffic against a round-robin turn model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
`ifdef ARVI_RF_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_ex_valid, i_ld_valid;
  logic [4:0]      i_ex_rd, i_ld_rd;
  logic [XLEN-1:0] i_ex_data, i_ld_data;
  logic            o_ex_ready, o_ld_ready, o_wen, o_init_busy;
  logic [4:0]      o_wnum;
  logic [XLEN-1:0] o_wd;

  typedef struct {
    logic [4:0]      num;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_clear_left = 0;
  bit  m_ld_turn = 1'b0;  // LD wins the next tie when set

  always #5 i_clk = ~i_clk;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready), .i_ex_rd(i_ex_rd), .i_ex_data(i_ex_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_wen(o_wen), .o_wnum(o_wnum), .o_wd(o_wd), .o_init_busy(o_init_busy)
  );

  function automatic void check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_wr(logic [4:0] num, logic [XLEN-1:0] data);
    wr_t w;
    w.num  = num;
    w.data = data;
    exp_q.push_back(w);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ld_turn = 1'b0;
    m_clear_left = 0;
    if (CLEAR_EN) begin
      m_clear_left = 31;
      for (int i = 1; i < 32; i++) push_wr(5'(i), '0);
    end
  endtask

  // Drive one cycle of requests, check readies mid-cycle, return at posedge+1.
  task automatic cycle(input bit ev, input logic [4:0] erd, input logic [XLEN-1:0] ed,
                       input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldd,
                       output bit eg, output bit lg);
    bit exp_er, exp_lr;
    i_ex_valid = ev; i_ex_rd = erd; i_ex_data = ed;
    i_ld_valid = lv; i_ld_rd = lrd; i_ld_data = ldd;
    @(negedge i_clk);
    check("init_busy", o_init_busy, m_clear_left > 0);
    eg = 1'b0;
    lg = 1'b0;
    if (m_clear_left > 0) begin
      exp_er = 1'b0;
      exp_lr = 1'b0;
      m_clear_left--;
    end else begin
      exp_er = !(lv && m_ld_turn);
      exp_lr = !(ev && !m_ld_turn);
      eg = ev && exp_er;
      lg = lv && exp_lr;
      if (eg) begin
        if (erd != 5'd0) push_wr(erd, ed);
        m_ld_turn = 1'b1;
      end else if (lg) begin
        if (lrd != 5'd0) push_wr(lrd, ldd);
        m_ld_turn = 1'b0;
      end
    end
    check("ex_ready", o_ex_ready, exp_er);
    check("ld_ready", o_ld_ready, exp_lr);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(output bit eg, output bit lg);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, eg, lg);
  endtask

  // Monitor: every enabled write on the port must match the oldest expected write.
  initial forever begin : monitor
    wr_t e;
    @(negedge i_clk);
    if (i_rstn && o_wen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got wnum %0d wd 0x%0h, expected no write", o_wnum, o_wd);
      end else begin
        e = exp_q.pop_front();
        check("wr_wnum", o_wnum, e.num);
        check("wr_wd", o_wd, e.data);
      end
    end
  end

  initial begin
    bit eg, lg, ep, lp;
    logic [4:0] erd, lrd;
    logic [XLEN-1:0] ed, ldd;
    int cont_wnum[4];
    int cont_eg[4];
    cont_wnum = '{3, 4, 3, 4};
    cont_eg   = '{1, 0, 1, 0};
    ep = 0; lp = 0; erd = 0; lrd = 0; ed = 0; ldd = 0;
    i_ex_valid = 0; i_ex_rd = 0; i_ex_data = 0;
    i_ld_valid = 0; i_ld_rd = 0; i_ld_data = 0;

    @(posedge i_clk); #1;
    check("rst_wen", o_wen, 0);
    check("rst_wnum", o_wnum, 0);
    check("rst_wd", o_wd, 0);
    check("rst_busy", o_init_busy, CLEAR_EN);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    model_reset();
    repeat (m_clear_left) idle(eg, lg);

    // First request after reset (or after the clear sequence).
    cycle(1, 5'd1, 32'h1, 0, 5'd0, '0, eg, lg);
    check("first_wen", o_wen, 1);
    check("first_wnum", o_wnum, 1);

    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0, eg, lg);
    check("ex_wen", o_wen, 1);
    check("ex_wnum", o_wnum, 5);
    check("ex_wd", o_wd, 32'hDEADBEEF);
    idle(eg, lg);
    check("idle_wen", o_wen, 0);
    check("idle_wnum_hold", o_wnum, 5);

    cycle(0, 5'd0, '0, 1, 5'd0, 32'h55, eg, lg);
    check("x0_wen", o_wen, 0);
    check("x0_wnum", o_wnum, 0);
    check("x0_wd", o_wd, 32'h55);
    cycle(0, 5'd0, '0, 1, 5'd7, 32'h77, eg, lg);
    check("ld7_wen", o_wen, 1);
    check("ld7_wnum", o_wnum, 7);

    for (int i = 0; i < 4; i++) begin
      bit ex_won;
      ex_won = o_ex_ready;
      cycle(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, eg, lg);
      check("cont_ex_grant", ex_won, cont_eg[i]);
      check("cont_wnum", o_wnum, cont_wnum[i]);
    end

    repeat (400) begin
      if (!ep && $urandom_range(0, 2) != 0) begin
        ep = 1; erd = 5'($urandom_range(0, 31)); ed = $urandom;
      end
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1; lrd = 5'($urandom_range(0, 31)); ldd = $urandom;
      end
      cycle(ep, erd, ed, lp, lrd, ldd, eg, lg);
      if (eg) ep = 0;
      if (lg) lp = 0;
    end

    // Reset while a write is on the port.
    cycle(1, 5'd9, 32'hA5A5A5A5, 0, 5'd0, '0, eg, lg);
    check("pre_rst_wen", o_wen, 1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("async_rst_wen", o_wen, 0);
    check("async_rst_wnum", o_wnum, 0);
    check("async_rst_wd", o_wd, 0);
    check("async_rst_busy", o_init_busy, CLEAR_EN);
    exp_q.delete();
    i_ex_valid = 0; i_ld_valid = 0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    model_reset();
    idle(eg, lg);
    if (CLEAR_EN) check("clear_restart_wnum", o_wnum, 1);
    while (m_clear_left > 0) idle(eg, lg);

    ep = 0; lp = 0;
    repeat (150) begin
      if (!ep && $urandom_range(0, 1) != 0) begin
        ep = 1; erd = 5'($urandom_range(0, 31)); ed = $urandom;
      end
      if (!lp && $urandom_range(0, 1) != 0) begin
        lp = 1; lrd = 5'($urandom_range(0, 31)); ldd = $urandom;
      end
      cycle(ep, erd, ed, lp, lrd, ldd, eg, lg);
      if (eg) ep = 0;
      if (lg) lp = 0;
    end
    repeat (3) idle(eg, lg);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
